scan_elevator_ctrl: RTL and testbench

Parametrised successor to the fixed 8-floor elevator controller: a single-car SCAN-scheduling controller for any floor count, with latched inside/hall-up/hall-down request masks, a per-floor travel timer and a door-dwell timer. It sits between the input manager and the simulator/display path, replacing the separate controller and simulator pair. It drives the current floor, direction, moving and door status directly.

---
 rtl/elevator_pkg.sv | 21 ++
 rtl/cycle_timer.sv | 34 +++
 rtl/scan_elevator_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_scan_elevator_ctrl.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
// Shared types and constants for the SCAN elevator controller and its bench.
package elevator_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_MOVE,
      ST_DOOR
   } state_e;

   localparam logic [1:0] KIND_IN = 2'b00;
   localparam logic [1:0] KIND_UP = 2'b01;
   localparam logic [1:0] KIND_DN = 2'b10;

   localparam logic DIR_UP = 1'b1;
   localparam logic DIR_DN = 1'b0;

   function automatic int max_i(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/cycle_timer.sv
// Loadable down-counter; expire is high during the last counted cycle.
module cycle_timer #(
   parameter int W = 3
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         expire
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = load_val;
      end else if (count_q != '0) begin
         count_d = count_q - W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign expire = (count_q == W'(1));

endmodule

// File: rtl/scan_elevator_ctrl.sv
// Single-car SCAN elevator controller with latched request masks and a shared
// travel/door timer.
module scan_elevator_ctrl
   import elevator_pkg::*;
#(
   parameter int  FLOORS        = 8,
   parameter int  TRAVEL_CYCLES = 4,
   parameter int  DOOR_CYCLES   = 3,
   localparam int FW            = $clog2(FLOORS)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   input  logic [FW-1:0]     req_floor,
   input  logic [1:0]        req_kind,
   output logic [FW-1:0]     cur_floor,
   output logic              dir,
   output logic              moving,
   output logic              door_open,
   output logic              arrived,
   output logic [FLOORS-1:0] pend_in,
   output logic [FLOORS-1:0] pend_up,
   output logic [FLOORS-1:0] pend_dn
);

   localparam int TW = $clog2(max_i(TRAVEL_CYCLES, DOOR_CYCLES) + 1);
   localparam logic [TW-1:0] TRAVEL_LD = TW'(TRAVEL_CYCLES);
   localparam logic [TW-1:0] DOOR_LD   = TW'(DOOR_CYCLES);

   state_e            state_q, state_d;
   logic [FW-1:0]     cur_floor_q, cur_floor_d;
   logic              dir_q, dir_d;
   logic              arrived_q, arrived_d;
   logic [FLOORS-1:0] pend_in_q, pend_in_d;
   logic [FLOORS-1:0] pend_up_q, pend_up_d;
   logic [FLOORS-1:0] pend_dn_q, pend_dn_d;

   logic              tmr_load;
   logic [TW-1:0]     tmr_val;
   logic              tmr_expire;

   logic              req_ok, door_hit;
   logic [FW-1:0]     next_floor;
   logic [FLOORS-1:0] pend_any;
   logic [FLOORS-1:0] oh_req, oh_cur, oh_nxt;
   logic [FLOORS-1:0] above_cur, below_cur, above_nxt, below_nxt;
   logic              ahead_cur_dir, ahead_cur_opp, ahead_nxt_dir;
   logic [FLOORS-1:0] set_in, set_up, set_dn;
   logic [FLOORS-1:0] clr_in, clr_up, clr_dn;
   logic              hall_dir_hit, hall_opp_hit, serve;

   cycle_timer #(.W(TW)) u_timer (
      .clk      (clk),
      .reset    (reset),
      .load     (tmr_load),
      .load_val (tmr_val),
      .expire   (tmr_expire)
   );

   // Request filtering plus the one-hot and thermometer masks behind ahead().
   always_comb begin
      req_ok = req_valid
               && (int'(req_floor) < FLOORS)
               && (req_kind != 2'b11)
               && !((req_kind == KIND_UP) && (int'(req_floor) == FLOORS - 1))
               && !((req_kind == KIND_DN) && (req_floor == '0));
      door_hit = req_ok && (state_q == ST_DOOR) && (req_floor == cur_floor_q)
                 && ((req_kind == KIND_IN)
                     || ((req_kind == KIND_UP) && (dir_q == DIR_UP))
                     || ((req_kind == KIND_DN) && (dir_q == DIR_DN)));
      next_floor = (dir_q == DIR_UP) ? cur_floor_q + FW'(1) : cur_floor_q - FW'(1);
      pend_any   = pend_in_q | pend_up_q | pend_dn_q;
      for (int i = 0; i < FLOORS; i++) begin
         oh_req[i]    = (req_floor == FW'(i));
         oh_cur[i]    = (cur_floor_q == FW'(i));
         oh_nxt[i]    = (next_floor == FW'(i));
         above_cur[i] = (FW'(i) > cur_floor_q);
         below_cur[i] = (FW'(i) < cur_floor_q);
         above_nxt[i] = (FW'(i) > next_floor);
         below_nxt[i] = (FW'(i) < next_floor);
      end
      ahead_cur_dir = |(pend_any & ((dir_q == DIR_UP) ? above_cur : below_cur));
      ahead_cur_opp = |(pend_any & ((dir_q == DIR_UP) ? below_cur : above_cur));
      ahead_nxt_dir = |(pend_any & ((dir_q == DIR_UP) ? above_nxt : below_nxt));
      set_in = (req_ok && !door_hit && (req_kind == KIND_IN)) ? oh_req : '0;
      set_up = (req_ok && !door_hit && (req_kind == KIND_UP)) ? oh_req : '0;
      set_dn = (req_ok && !door_hit && (req_kind == KIND_DN)) ? oh_req : '0;
      hall_dir_hit = |(((dir_q == DIR_UP) ? pend_up_q : pend_dn_q) & oh_nxt);
      hall_opp_hit = |(((dir_q == DIR_UP) ? pend_dn_q : pend_up_q) & oh_nxt);
      serve = (|(pend_in_q & oh_nxt)) || hall_dir_hit || (hall_opp_hit && !ahead_nxt_dir);
   end

   // SCAN scheduler: decides motion, service and which mask bits to clear.
   always_comb begin
      state_d     = state_q;
      cur_floor_d = cur_floor_q;
      dir_d       = dir_q;
      arrived_d   = 1'b0;
      clr_in      = '0;
      clr_up      = '0;
      clr_dn      = '0;
      tmr_load    = 1'b0;
      tmr_val     = TRAVEL_LD;
      case (state_q)
         ST_IDLE: begin
            if (|(pend_any & oh_cur)) begin
               clr_in   = oh_cur;
               clr_up   = oh_cur;
               clr_dn   = oh_cur;
               state_d  = ST_DOOR;
               tmr_load = 1'b1;
               tmr_val  = DOOR_LD;
            end else if (ahead_cur_dir) begin
               state_d  = ST_MOVE;
               tmr_load = 1'b1;
            end else if (ahead_cur_opp) begin
               dir_d    = ~dir_q;
               state_d  = ST_MOVE;
               tmr_load = 1'b1;
            end
         end
         ST_MOVE: begin
            if (tmr_expire) begin
               cur_floor_d = next_floor;
               arrived_d   = 1'b1;
               tmr_load    = 1'b1;
               if (serve) begin
                  clr_in = oh_nxt;
                  if (dir_q == DIR_UP) clr_up = oh_nxt;
                  else                 clr_dn = oh_nxt;
                  if (!ahead_nxt_dir) begin
                     clr_up = oh_nxt;
                     clr_dn = oh_nxt;
                     dir_d  = ~dir_q;
                  end
                  state_d = ST_DOOR;
                  tmr_val = DOOR_LD;
               end
            end
         end
         ST_DOOR: begin
            if (door_hit) begin
               tmr_load = 1'b1;
               tmr_val  = DOOR_LD;
            end else if (tmr_expire) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      pend_in_d = (pend_in_q | set_in) & ~clr_in;
      pend_up_d = (pend_up_q | set_up) & ~clr_up;
      pend_dn_d = (pend_dn_q | set_dn) & ~clr_dn;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         cur_floor_q <= '0;
         dir_q       <= DIR_UP;
         arrived_q   <= 1'b0;
         pend_in_q   <= '0;
         pend_up_q   <= '0;
         pend_dn_q   <= '0;
      end else begin
         state_q     <= state_d;
         cur_floor_q <= cur_floor_d;
         dir_q       <= dir_d;
         arrived_q   <= arrived_d;
         pend_in_q   <= pend_in_d;
         pend_up_q   <= pend_up_d;
         pend_dn_q   <= pend_dn_d;
      end
   end

   assign cur_floor = cur_floor_q;
   assign dir       = dir_q;
   assign moving    = (state_q == ST_MOVE);
   assign door_open = (state_q == ST_DOOR);
   assign arrived   = arrived_q;
   assign pend_in   = pend_in_q;
   assign pend_up   = pend_up_q;
   assign pend_dn   = pend_dn_q;

`ifndef SYNTHESIS
   a_floor_range: assert property (@(posedge clk) disable iff (!reset)
      (int'(cur_floor_q) < FLOORS));
`endif

endmodule

// File: tb/tb_scan_elevator_ctrl.sv
// Randomized and directed bench for scan_elevator_ctrl against a behavioural
// SCAN model kept as plain integer arrays.
module tb_scan_elevator_ctrl;
   import elevator_pkg::*;

   localparam int FLOORS = 8;
   localparam int TRAVEL = 4;
   localparam int DOOR   = 3;
   localparam int FW     = 3;
   localparam int M_IDLE = 0;
   localparam int M_MOVE = 1;
   localparam int M_DOOR = 2;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic              req_valid = 1'b0;
   logic [FW-1:0]     req_floor = '0;
   logic [1:0]        req_kind = '0;
   logic [FW-1:0]     cur_floor;
   logic              dir, moving, door_open, arrived;
   logic [FLOORS-1:0] pend_in, pend_up, pend_dn;

   logic              b_req_valid = 1'b0;
   logic [2:0]        b_req_floor = '0;
   logic [1:0]        b_req_kind = '0;
   logic [2:0]        b_cur_floor;
   logic              b_dir, b_moving, b_door_open, b_arrived;
   logic [5:0]        b_pend_in, b_pend_up, b_pend_dn;

   int passCount = 0;
   int totalCount = 0;

   int m_in[FLOORS];
   int m_up[FLOORS];
   int m_dn[FLOORS];
   int m_floor, m_dir, m_mode, m_left, m_arr;

   scan_elevator_ctrl #(.FLOORS(FLOORS), .TRAVEL_CYCLES(TRAVEL), .DOOR_CYCLES(DOOR)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_floor(req_floor),
      .req_kind(req_kind), .cur_floor(cur_floor), .dir(dir), .moving(moving),
      .door_open(door_open), .arrived(arrived), .pend_in(pend_in),
      .pend_up(pend_up), .pend_dn(pend_dn)
   );

   scan_elevator_ctrl #(.FLOORS(6), .TRAVEL_CYCLES(TRAVEL), .DOOR_CYCLES(DOOR)) dut6 (
      .clk(clk), .reset(reset), .req_valid(b_req_valid), .req_floor(b_req_floor),
      .req_kind(b_req_kind), .cur_floor(b_cur_floor), .dir(b_dir), .moving(b_moving),
      .door_open(b_door_open), .arrived(b_arrived), .pend_in(b_pend_in),
      .pend_up(b_pend_up), .pend_dn(b_pend_dn)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      totalCount++;
      if (observed === expected) passCount++;
      else $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
   endtask

   function automatic bit pendingAt(int g);
      return (m_in[g] != 0) || (m_up[g] != 0) || (m_dn[g] != 0);
   endfunction

   function automatic bit aheadOf(int f, int d);
      for (int g = 0; g < FLOORS; g++)
         if (((d != 0 && g > f) || (d == 0 && g < f)) && pendingAt(g)) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [FLOORS-1:0] packMask(input int arr[FLOORS]);
      logic [FLOORS-1:0] v;
      for (int g = 0; g < FLOORS; g++) v[g] = (arr[g] != 0);
      return v;
   endfunction

   task automatic modelReset();
      m_floor = 0; m_dir = 1; m_mode = M_IDLE; m_left = 0; m_arr = 0;
      for (int g = 0; g < FLOORS; g++) begin
         m_in[g] = 0; m_up[g] = 0; m_dn[g] = 0;
      end
   endtask

   // One clock edge of the SCAN rules: decide on old masks, then set, then clear.
   task automatic modelStep(input bit v, input int f, input int k);
      bit accept, doorhit, srv, ah;
      int clrFloor, nf;
      bit cIn, cUp, cDn;
      clrFloor = -1; cIn = 0; cUp = 0; cDn = 0;
      accept = v && (f < FLOORS) && (k != 3) && !(k == 1 && f == FLOORS - 1)
               && !(k == 2 && f == 0);
      doorhit = accept && (m_mode == M_DOOR) && (f == m_floor)
                && (k == 0 || (k == 1 && m_dir == 1) || (k == 2 && m_dir == 0));
      m_arr = 0;
      case (m_mode)
         M_IDLE: begin
            if (pendingAt(m_floor)) begin
               clrFloor = m_floor; cIn = 1; cUp = 1; cDn = 1;
               m_mode = M_DOOR; m_left = DOOR;
            end else if (aheadOf(m_floor, m_dir)) begin
               m_mode = M_MOVE; m_left = TRAVEL;
            end else if (aheadOf(m_floor, 1 - m_dir)) begin
               m_dir = 1 - m_dir; m_mode = M_MOVE; m_left = TRAVEL;
            end
         end
         M_MOVE: begin
            if (m_left == 1) begin
               nf = m_floor + ((m_dir != 0) ? 1 : -1);
               ah = aheadOf(nf, m_dir);
               srv = (m_in[nf] != 0) || ((m_dir != 0) ? m_up[nf] != 0 : m_dn[nf] != 0)
                     || (((m_dir != 0) ? m_dn[nf] != 0 : m_up[nf] != 0) && !ah);
               m_floor = nf; m_arr = 1;
               if (srv) begin
                  clrFloor = nf; cIn = 1;
                  cUp = (m_dir != 0); cDn = (m_dir == 0);
                  if (!ah) begin
                     cUp = 1; cDn = 1; m_dir = 1 - m_dir;
                  end
                  m_mode = M_DOOR; m_left = DOOR;
               end else begin
                  m_left = TRAVEL;
               end
            end else begin
               m_left--;
            end
         end
         default: begin
            if (doorhit) m_left = DOOR;
            else if (m_left == 1) m_mode = M_IDLE;
            else m_left--;
         end
      endcase
      if (accept && !doorhit) begin
         if (k == 0) m_in[f] = 1;
         else if (k == 1) m_up[f] = 1;
         else m_dn[f] = 1;
      end
      if (clrFloor >= 0) begin
         if (cIn) m_in[clrFloor] = 0;
         if (cUp) m_up[clrFloor] = 0;
         if (cDn) m_dn[clrFloor] = 0;
      end
   endtask

   task automatic compareAll();
      checkOutput("cur_floor", 32'(cur_floor), 32'(m_floor));
      checkOutput("dir", 32'(dir), 32'(m_dir));
      checkOutput("moving", 32'(moving), 32'(m_mode == M_MOVE));
      checkOutput("door_open", 32'(door_open), 32'(m_mode == M_DOOR));
      checkOutput("arrived", 32'(arrived), 32'(m_arr));
      checkOutput("pend_in", 32'(pend_in), 32'(packMask(m_in)));
      checkOutput("pend_up", 32'(pend_up), 32'(packMask(m_up)));
      checkOutput("pend_dn", 32'(pend_dn), 32'(packMask(m_dn)));
   endtask

   // Called at posedge+1; drives the request for the next edge and checks after it.
   task automatic applyStimulus(input bit v, input int f, input int k);
      req_valid = v;
      req_floor = FW'(f);
      req_kind  = 2'(k);
      @(posedge clk);
      modelStep(v, f, k);
      #1;
      compareAll();
      req_valid = 1'b0;
   endtask

   task automatic checkResetOutputs(input string pfx);
      checkOutput({pfx, "_cur_floor"}, 32'(cur_floor), 32'd0);
      checkOutput({pfx, "_dir"}, 32'(dir), 32'd1);
      checkOutput({pfx, "_moving"}, 32'(moving), 32'd0);
      checkOutput({pfx, "_door_open"}, 32'(door_open), 32'd0);
      checkOutput({pfx, "_arrived"}, 32'(arrived), 32'd0);
      checkOutput({pfx, "_masks"}, 32'({pend_in, pend_up, pend_dn}), 32'd0);
   endtask

   initial begin
      int nMove, nArr, nDoor, nStops;
      int stopFloor[2];
      int stopDir[2];
      bit prevDoor;

      modelReset();
      repeat (3) @(posedge clk);
      #1;
      checkResetOutputs("rst");
      reset = 1'b1;
      repeat (20) applyStimulus(0, 0, 0);
      checkOutput("idle_floor", 32'(cur_floor), 32'd0);

      applyStimulus(1, 5, KIND_IN);
      checkOutput("req_latched", 32'(pend_in), 32'h20);
      nMove = 0; nArr = 0;
      for (int i = 0; i < 40 && !door_open; i++) begin
         applyStimulus(0, 0, 0);
         nMove += int'(moving);
         nArr  += int'(arrived);
      end
      checkOutput("move_cycles", 32'(nMove), 32'd20);
      checkOutput("arrivals", 32'(nArr), 32'd5);
      checkOutput("door_floor", 32'(cur_floor), 32'd5);
      nDoor = 0;
      for (int i = 0; i < 10 && door_open; i++) begin
         nDoor++;
         applyStimulus(0, 0, 0);
      end
      checkOutput("door_cycles", 32'(nDoor), 32'd3);
      checkOutput("pend_in_clear", 32'(pend_in), 32'd0);

      applyStimulus(1, 7, KIND_IN);
      applyStimulus(1, 2, KIND_DN);
      stopFloor[0] = -1; stopFloor[1] = -1; stopDir[0] = -1; stopDir[1] = -1;
      nStops = 0; prevDoor = 1'b0;
      for (int i = 0; i < 150 && (nStops < 2 || door_open); i++) begin
         applyStimulus(0, 0, 0);
         if (door_open && !prevDoor && nStops < 2) begin
            stopFloor[nStops] = int'(cur_floor);
            stopDir[nStops]   = int'(dir);
            nStops++;
         end
         prevDoor = door_open;
      end
      checkOutput("stop1_floor", 32'(stopFloor[0]), 32'd7);
      checkOutput("stop1_dir", 32'(stopDir[0]), 32'd0);
      checkOutput("stop2_floor", 32'(stopFloor[1]), 32'd2);
      checkOutput("pend_dn_clear", 32'(pend_dn), 32'd0);

      applyStimulus(1, 0, KIND_DN);
      applyStimulus(1, 7, KIND_UP);
      applyStimulus(1, 3, 3);
      checkOutput("ignored_masks", 32'({pend_in, pend_up, pend_dn}), 32'd0);
      b_req_valid = 1'b1; b_req_floor = 3'd6; b_req_kind = KIND_IN;
      applyStimulus(0, 0, 0);
      b_req_floor = 3'd7; b_req_kind = KIND_UP;
      applyStimulus(0, 0, 0);
      b_req_valid = 1'b0;
      checkOutput("range_masks", 32'({b_pend_in, b_pend_up, b_pend_dn}), 32'd0);
      b_req_valid = 1'b1; b_req_floor = 3'd5; b_req_kind = KIND_IN;
      applyStimulus(0, 0, 0);
      b_req_valid = 1'b0;
      checkOutput("range_top_ok", 32'(b_pend_in), 32'h20);

      applyStimulus(1, 4, KIND_IN);
      for (int i = 0; i < 40 && !door_open; i++) applyStimulus(0, 0, 0);
      nDoor = door_open ? 1 : 0;
      applyStimulus(1, 4, KIND_IN);
      checkOutput("reload_no_latch", 32'(pend_in), 32'd0);
      for (int i = 0; i < 10 && door_open; i++) begin
         nDoor++;
         applyStimulus(0, 0, 0);
      end
      checkOutput("door_reload_len", 32'(nDoor), 32'd4);

      applyStimulus(1, 3, KIND_IN);
      for (int i = 0; i < 40 && !(door_open && cur_floor == 3'd3); i++) applyStimulus(0, 0, 0);
      for (int i = 0; i < 10 && door_open; i++) applyStimulus(0, 0, 0);
      applyStimulus(1, 6, KIND_IN);
      applyStimulus(0, 0, 0);
      applyStimulus(0, 0, 0);
      checkOutput("pre_rst_moving", 32'(moving), 32'd1);
      checkOutput("pre_rst_floor", 32'(cur_floor), 32'd3);
      #2 reset = 1'b0;
      #1;
      checkResetOutputs("arst");
      modelReset();
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      repeat (5) applyStimulus(0, 0, 0);
      applyStimulus(1, 2, KIND_IN);
      repeat (15) applyStimulus(0, 0, 0);

      repeat (2000) begin
         if ($urandom_range(0, 99) < 25)
            applyStimulus(1, int'($urandom_range(0, FLOORS - 1)), int'($urandom_range(0, 3)));
         else
            applyStimulus(0, 0, 0);
      end

      $display("%0d/%0d checks passed", passCount, totalCount);
      $finish;
   end

endmodule
